// File: rtl/cpu_control_unit.sv
// Control unit for the 8-bit computer: fetches and decodes instruction bytes,
// holds PC/ACC/register file, drives the external combinational ALU.
module cpu_control_unit #(
   parameter logic [7:0]  RESET_PC = 8'h00,
   parameter int unsigned NREGS    = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [7:0] imem_addr,
   input  logic [7:0] imem_data,
   output logic [1:0] alu_control,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [7:0] alu_pc,
   input  logic [7:0] alu_result,
   output logic [7:0] acc,
   output logic       busy,
   output logic       halted
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_IMM    = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] acc_q, acc_d;
   logic [7:0] instr_q, instr_d;
   logic [1:0] alu_ctl_q, alu_ctl_d;
   logic [7:0] alu_b_q, alu_b_d;
   logic       busy_q, busy_d;
   logic       halted_q, halted_d;
   logic [7:0] regs_q [NREGS];
   logic [7:0] rf_rd_s;
   logic       reg_we_s;

   // Out-of-range register indices read as zero.
   always_comb begin
      rf_rd_s = 8'h00;
      if (32'(imem_data[3:0]) < NREGS) begin
         rf_rd_s = regs_q[imem_data[3:0]];
      end else begin
         rf_rd_s = 8'h00;
      end
   end

   // Next-state, datapath updates and ALU drive selection.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      acc_d     = acc_q;
      instr_d   = instr_q;
      alu_ctl_d = 2'b00;
      alu_b_d   = 8'h00;
      reg_we_s  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_FETCH;
            else       state_d = S_IDLE;
         end
         S_FETCH: begin
            instr_d = imem_data;
            pc_d    = pc_q + 8'd1;
            state_d = S_EXEC;
            // ALU operands are registered here so they are stable through EXEC.
            if (imem_data[7:6] == 2'b00) begin
               alu_ctl_d = imem_data[5:4];
               alu_b_d   = rf_rd_s;
            end else begin
               alu_ctl_d = 2'b00;
               alu_b_d   = 8'h00;
            end
         end
         S_EXEC: begin
            case (instr_q[7:6])
               2'b00: begin
                  if (instr_q[5:4] == 2'b10) pc_d  = alu_result;
                  else                       acc_d = alu_result;
                  state_d = S_FETCH;
               end
               2'b01: state_d = S_IMM;
               2'b10: begin
                  reg_we_s = 1'b1;
                  state_d  = S_FETCH;
               end
               2'b11: begin
                  if (instr_q[5:0] == 6'd0) state_d = S_HALTED;
                  else                      state_d = S_FETCH;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_IMM: begin
            acc_d   = imem_data;
            pc_d    = pc_q + 8'd1;
            state_d = S_FETCH;
         end
         S_HALTED: begin
            if (start) state_d = S_FETCH;
            else       state_d = S_HALTED;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_IMM);
      halted_d = (state_d == S_HALTED);
   end

   // State, PC, ACC, instruction and registered output flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         acc_q     <= 8'h00;
         instr_q   <= 8'h00;
         alu_ctl_q <= 2'b00;
         alu_b_q   <= 8'h00;
         busy_q    <= 1'b0;
         halted_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         acc_q     <= acc_d;
         instr_q   <= instr_d;
         alu_ctl_q <= alu_ctl_d;
         alu_b_q   <= alu_b_d;
         busy_q    <= busy_d;
         halted_q  <= halted_d;
      end
   end

   // Register file; stores to indices beyond the file depth are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= 8'h00;
         end
      end else if (reg_we_s && (32'(instr_q[3:0]) < NREGS)) begin
         regs_q[instr_q[3:0]] <= acc_q;
      end
   end

   assign imem_addr   = pc_q;
   assign alu_pc      = pc_q;
   assign alu_a       = acc_q;
   assign acc         = acc_q;
   assign alu_control = alu_ctl_q;
   assign alu_b       = alu_b_q;
   assign busy        = busy_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit with a behavioural ALU
// and instruction memory; a second instance covers RESET_PC = 8'hFF.
module tb_cpu_control_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       start_w = 1'b0;
   logic [7:0] mem   [256];
   logic [7:0] mem_w [256];

   logic [7:0] imem_addr, imem_data, alu_a, alu_b, alu_pc, alu_result, acc;
   logic [1:0] alu_control;
   logic       busy, halted;

   logic [7:0] w_imem_addr, w_imem_data, w_alu_a, w_alu_b, w_alu_pc, w_alu_result, w_acc;
   logic [1:0] w_alu_control;
   logic       w_busy, w_halted;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [7:0] alu_model(input logic [1:0] c, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] p);
      case (c)
         2'b00:   return a + b;
         2'b01:   return ~(a & b);
         2'b10:   return (a == 8'h00) ? p : b;
         2'b11:   return {7'd0, (a < b)};
         default: return 8'h00;
      endcase
   endfunction

   assign imem_data    = mem[imem_addr];
   assign alu_result   = alu_model(alu_control, alu_a, alu_b, alu_pc);
   assign w_imem_data  = mem_w[w_imem_addr];
   assign w_alu_result = alu_model(w_alu_control, w_alu_a, w_alu_b, w_alu_pc);

   cpu_control_unit #(.RESET_PC(8'h00), .NREGS(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b), .alu_pc(alu_pc),
      .alu_result(alu_result), .acc(acc), .busy(busy), .halted(halted)
   );

   cpu_control_unit #(.RESET_PC(8'hFF), .NREGS(16)) u_dut_w (
      .clk(clk), .rst_n(rst_n), .start(start_w),
      .imem_addr(w_imem_addr), .imem_data(w_imem_data),
      .alu_control(w_alu_control), .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_pc(w_alu_pc),
      .alu_result(w_alu_result), .acc(w_acc), .busy(w_busy), .halted(w_halted)
   );

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      start   = 1'b0;
      start_w = 1'b0;
      rst_n   = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic load_prog(input logic [55:0] p);
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      for (int i = 0; i < 7; i++) mem[i] = p[55-8*i -: 8];
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic run_to_halt(input int max);
      int n = 0;
      while (!halted && n < max) begin
         tick(1);
         n++;
      end
      check_val("halt_reached", {7'd0, halted}, 8'h01);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_w[i] = 8'h00;
      mem_w[8'hFF] = 8'hC1;
      mem_w[8'h00] = 8'hC0;

      // Reset state and LDI/HALT timing, then resume from HALTED with start held.
      load_prog({8'h40, 8'h05, 8'hC0, 8'hC0, 8'h00, 8'h00, 8'h00});
      do_reset();
      check_val("rst_acc", acc, 8'h00);
      check_val("rst_addr", imem_addr, 8'h00);
      check_val("rst_busy", {7'd0, busy}, 8'h00);
      check_val("rst_halted", {7'd0, halted}, 8'h00);
      check_val("rst_ctl", {6'd0, alu_control}, 8'h00);
      check_val("rst_alub", alu_b, 8'h00);
      check_val("rst_w_addr", w_imem_addr, 8'hFF);
      pulse_start();
      check_val("t1_fetch0", imem_addr, 8'h00);
      check_val("t1_busy", {7'd0, busy}, 8'h01);
      tick(2);
      check_val("t1_imm_addr", imem_addr, 8'h01);
      tick(1);
      check_val("t1_acc", acc, 8'h05);
      check_val("t1_fetch2", imem_addr, 8'h02);
      tick(1);
      check_val("t1_not_halted", {7'd0, halted}, 8'h00);
      tick(1);
      check_val("t1_halted", {7'd0, halted}, 8'h01);
      check_val("t1_pc", imem_addr, 8'h03);
      check_val("t1_idle_busy", {7'd0, busy}, 8'h00);
      start = 1'b1;
      tick(1);
      check_val("t1_resume_addr", imem_addr, 8'h03);
      check_val("t1_resume_halted", {7'd0, halted}, 8'h00);
      tick(2);
      check_val("t1_rehalt", {7'd0, halted}, 8'h01);
      check_val("t1_rehalt_pc", imem_addr, 8'h04);
      tick(1);
      check_val("t1_held_start", {7'd0, busy}, 8'h01);
      check_val("t1_held_addr", imem_addr, 8'h04);
      start = 1'b0;

      // LDI 3; ST R1; LDI 4; ADD R1; HALT, with a stray start pulse while busy.
      load_prog({8'h40, 8'h03, 8'h81, 8'h40, 8'h04, 8'h01, 8'hC0});
      do_reset();
      pulse_start();
      tick(3);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(5);
      check_val("t2_add_alub", alu_b, 8'h03);
      check_val("t2_add_ctl", {6'd0, alu_control}, 8'h00);
      check_val("t2_add_acc_in", acc, 8'h04);
      run_to_halt(20);
      check_val("t2_acc", acc, 8'h07);
      check_val("t2_pc", imem_addr, 8'h07);

      // Branch taken: ACC=1, R2=0x10.
      load_prog({8'h40, 8'h10, 8'h82, 8'h40, 8'h01, 8'h22, 8'hC0});
      mem[8'h10] = 8'hC0;
      do_reset();
      pulse_start();
      tick(9);
      check_val("br_ctl", {6'd0, alu_control}, 8'h02);
      check_val("br_alub", alu_b, 8'h10);
      tick(1);
      check_val("br_taken_addr", imem_addr, 8'h10);
      check_val("br_taken_acc", acc, 8'h01);

      // Branch not taken: ACC=0.
      load_prog({8'h40, 8'h10, 8'h82, 8'h40, 8'h00, 8'h22, 8'hC0});
      do_reset();
      pulse_start();
      tick(10);
      check_val("br_nt_addr", imem_addr, 8'h06);
      check_val("br_nt_acc", acc, 8'h00);

      // NAND and set-less-than.
      load_prog({8'h40, 8'h3C, 8'h81, 8'h40, 8'hF0, 8'h11, 8'hC0});
      do_reset();
      pulse_start();
      run_to_halt(20);
      check_val("nand_acc", acc, 8'hCF);
      load_prog({8'h40, 8'h07, 8'h81, 8'h40, 8'h03, 8'h31, 8'hC0});
      do_reset();
      pulse_start();
      run_to_halt(20);
      check_val("slt_lt_acc", acc, 8'h01);
      load_prog({8'h40, 8'h03, 8'h81, 8'h40, 8'h07, 8'h31, 8'hC0});
      do_reset();
      pulse_start();
      run_to_halt(20);
      check_val("slt_ge_acc", acc, 8'h00);

      // LDI located at 0xFE: immediate read from 0xFF, PC wraps to 0x00.
      load_prog({8'h40, 8'hFE, 8'h83, 8'h40, 8'h01, 8'h23, 8'hC0});
      mem[8'hFE] = 8'h40;
      mem[8'hFF] = 8'h5A;
      do_reset();
      pulse_start();
      tick(10);
      check_val("wrap_br_addr", imem_addr, 8'hFE);
      tick(2);
      check_val("wrap_imm_addr", imem_addr, 8'hFF);
      tick(1);
      check_val("wrap_imm_acc", acc, 8'h5A);
      check_val("wrap_imm_pc", imem_addr, 8'h00);

      // RESET_PC = 0xFF with a NOP there: next fetch is at 0x00.
      do_reset();
      check_val("w_rst_addr", w_imem_addr, 8'hFF);
      start_w = 1'b1;
      tick(1);
      start_w = 1'b0;
      check_val("w_fetch_ff", w_imem_addr, 8'hFF);
      tick(2);
      check_val("w_fetch_wrap", w_imem_addr, 8'h00);
      check_val("w_busy", {7'd0, w_busy}, 8'h01);

      // Asynchronous reset during EXEC of ADD R1.
      load_prog({8'h40, 8'h05, 8'h81, 8'h01, 8'hC0, 8'h00, 8'h00});
      do_reset();
      pulse_start();
      tick(6);
      check_val("ar_pre_alub", alu_b, 8'h05);
      check_val("ar_pre_acc", acc, 8'h05);
      #2 rst_n = 1'b0;
      #1;
      check_val("ar_acc", acc, 8'h00);
      check_val("ar_addr", imem_addr, 8'h00);
      check_val("ar_busy", {7'd0, busy}, 8'h00);
      check_val("ar_alub", alu_b, 8'h00);
      tick(1);
      rst_n = 1'b1;
      tick(3);
      check_val("ar_rel_acc", acc, 8'h00);
      check_val("ar_rel_busy", {7'd0, busy}, 8'h00);
      check_val("ar_rel_addr", imem_addr, 8'h00);
      pulse_start();
      check_val("ar_restart_busy", {7'd0, busy}, 8'h01);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
